// File: rtl/rs_param.sv
// Reservation station: holds ALU instructions until both operands resolve, snoops N CDB ports,
// and dispatches the oldest ready entry through a valid/ready output register.
module rs_param #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 4,
    parameter int OP_W  = 6,
    parameter int N_CDB = 3,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    is_issue,
    input  logic [OP_W-1:0]         issue_opcode,
    input  logic [ROB_W-1:0]        issue_rob_id,
    input  logic [31:0]             issue_Vi,
    input  logic [31:0]             issue_Vj,
    input  logic [ROB_W-1:0]        issue_Qi,
    input  logic [ROB_W-1:0]        issue_Qj,
    input  logic                    issue_Ri,
    input  logic                    issue_Rj,
    input  logic [31:0]             issue_imm,
    input  logic [31:0]             issue_pc,
    output logic                    rs_full,
    output logic [IDX_W:0]          rs_count,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  cdb_rob_id,
    input  logic [N_CDB*32-1:0]     cdb_value,
    output logic                    work_en,
    input  logic                    alu_ready,
    output logic [ROB_W-1:0]        rob_id_from_rs,
    output logic [OP_W-1:0]         opcode_from_rs,
    output logic [31:0]             val1,
    output logic [31:0]             val2,
    output logic [31:0]             imm_from_rs,
    output logic [31:0]             pc_from_rs
);

    localparam int DATA_W = 32;
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_busy, r_ri, r_rj;
    logic [DATA_W-1:0] r_vi [DEPTH];
    logic [DATA_W-1:0] r_vj [DEPTH];
    logic [ROB_W-1:0]  r_qi [DEPTH];
    logic [ROB_W-1:0]  r_qj [DEPTH];
    logic [ROB_W-1:0]  r_rob [DEPTH];
    logic [OP_W-1:0]   r_op [DEPTH];
    logic [DATA_W-1:0] r_imm [DEPTH];
    logic [DATA_W-1:0] r_pc [DEPTH];
    // r_older[j][i] set means entry j was issued before entry i
    logic [DEPTH-1:0]  r_older [DEPTH];
    logic [IDX_W:0]    r_count;

    logic              r_work_en;
    logic [ROB_W-1:0]  r_out_rob;
    logic [OP_W-1:0]   r_out_op;
    logic [DATA_W-1:0] r_out_v1, r_out_v2, r_out_imm, r_out_pc;

    logic [DEPTH-1:0]  w_ready, w_oldest;
    logic [IDX_W-1:0]  w_sel_idx, w_free_idx;
    logic              w_any_ready, w_full, w_issue, w_load;
    logic [DATA_W:0]   w_byp_i, w_byp_j;
    logic [DATA_W:0]   w_wake_i [DEPTH];
    logic [DATA_W:0]   w_wake_j [DEPTH];

    // Returns {hit, value}; the lowest-indexed matching port wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]       tag,
        input logic [N_CDB-1:0]       vld,
        input logic [N_CDB*ROB_W-1:0] ids,
        input logic [N_CDB*32-1:0]    vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = N_CDB-1; k >= 0; k--) begin
            if (vld[k] && ids[k*ROB_W +: ROB_W] == tag)
                res = {1'b1, vals[k*32 +: 32]};
        end
        return res;
    endfunction

    always_comb begin
        w_ready     = '0;
        w_oldest    = '0;
        w_any_ready = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++)
            w_ready[i] = r_busy[i] && r_ri[i] && r_rj[i];
        for (int i = 0; i < DEPTH; i++) begin
            w_oldest[i] = w_ready[i];
            for (int j = 0; j < DEPTH; j++)
                if (w_ready[j] && r_older[j][i]) w_oldest[i] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_oldest[i]) begin
                w_any_ready = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake_i[i] = cdb_lookup(r_qi[i], cdb_valid, cdb_rob_id, cdb_value);
            w_wake_j[i] = cdb_lookup(r_qj[i], cdb_valid, cdb_rob_id, cdb_value);
        end
    end

    assign w_byp_i = cdb_lookup(issue_Qi, cdb_valid, cdb_rob_id, cdb_value);
    assign w_byp_j = cdb_lookup(issue_Qj, cdb_valid, cdb_rob_id, cdb_value);
    assign w_full  = (r_count == CNT_FULL);
    assign w_issue = is_issue && !w_full;
    assign w_load  = (!r_work_en || alu_ready) && w_any_ready;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_busy    <= '0;
            r_ri      <= '0;
            r_rj      <= '0;
            r_count   <= '0;
            r_work_en <= 1'b0;
            r_out_rob <= '0;
            r_out_op  <= '0;
            r_out_v1  <= '0;
            r_out_v2  <= '0;
            r_out_imm <= '0;
            r_out_pc  <= '0;
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && !r_ri[i] && w_wake_i[i][DATA_W]) begin
                    r_ri[i] <= 1'b1;
                    r_vi[i] <= w_wake_i[i][DATA_W-1:0];
                end
                if (r_busy[i] && !r_rj[i] && w_wake_j[i][DATA_W]) begin
                    r_rj[i] <= 1'b1;
                    r_vj[i] <= w_wake_j[i][DATA_W-1:0];
                end
            end

            if (w_load) begin
                r_work_en         <= 1'b1;
                r_out_rob         <= r_rob[w_sel_idx];
                r_out_op          <= r_op[w_sel_idx];
                r_out_v1          <= r_vi[w_sel_idx];
                r_out_v2          <= r_vj[w_sel_idx];
                r_out_imm         <= r_imm[w_sel_idx];
                r_out_pc          <= r_pc[w_sel_idx];
                r_busy[w_sel_idx] <= 1'b0;
            end else if (!r_work_en || alu_ready) begin
                r_work_en <= 1'b0;
            end

            // The free slot is never busy, so it cannot collide with the wakeup or dispatch writes.
            if (w_issue) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= issue_opcode;
                r_rob[w_free_idx]  <= issue_rob_id;
                r_imm[w_free_idx]  <= issue_imm;
                r_pc[w_free_idx]   <= issue_pc;
                r_qi[w_free_idx]   <= issue_Qi;
                r_qj[w_free_idx]   <= issue_Qj;
                r_ri[w_free_idx]   <= issue_Ri || w_byp_i[DATA_W];
                r_rj[w_free_idx]   <= issue_Rj || w_byp_j[DATA_W];
                r_vi[w_free_idx]   <= issue_Ri ? issue_Vi : w_byp_i[DATA_W-1:0];
                r_vj[w_free_idx]   <= issue_Rj ? issue_Vj : w_byp_j[DATA_W-1:0];
                r_older[w_free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++)
                    r_older[j][w_free_idx] <= r_busy[j];
            end

            r_count <= r_count + {{IDX_W{1'b0}}, w_issue} - {{IDX_W{1'b0}}, w_load};
        end
    end

    assign rs_full        = w_full;
    assign rs_count       = r_count;
    assign work_en        = r_work_en;
    assign rob_id_from_rs = r_out_rob;
    assign opcode_from_rs = r_out_op;
    assign val1           = r_out_v1;
    assign val2           = r_out_v2;
    assign imm_from_rs    = r_out_imm;
    assign pc_from_rs     = r_out_pc;

endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param: reset/flush, wakeup, oldest-first order, backpressure, full and bypass.
module tb_rs_param;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, is_issue;
    logic [5:0]  issue_opcode;
    logic [3:0]  issue_rob_id, issue_Qi, issue_Qj;
    logic [31:0] issue_Vi, issue_Vj, issue_imm, issue_pc;
    logic        issue_Ri, issue_Rj;
    logic        rs_full;
    logic [4:0]  rs_count;
    logic [2:0]  cdb_valid;
    logic [11:0] cdb_rob_id;
    logic [95:0] cdb_value;
    logic        work_en, alu_ready;
    logic [3:0]  rob_id_from_rs;
    logic [5:0]  opcode_from_rs;
    logic [31:0] val1, val2, imm_from_rs, pc_from_rs;

    int errors = 0;
    int checks = 0;

    rs_param dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .is_issue(is_issue),
        .issue_opcode(issue_opcode), .issue_rob_id(issue_rob_id),
        .issue_Vi(issue_Vi), .issue_Vj(issue_Vj), .issue_Qi(issue_Qi), .issue_Qj(issue_Qj),
        .issue_Ri(issue_Ri), .issue_Rj(issue_Rj), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .rs_full(rs_full), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .work_en(work_en), .alu_ready(alu_ready),
        .rob_id_from_rs(rob_id_from_rs), .opcode_from_rs(opcode_from_rs),
        .val1(val1), .val2(val2), .imm_from_rs(imm_from_rs), .pc_from_rs(pc_from_rs)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cdb_set(input int port, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[port]          = 1'b1;
        cdb_rob_id[port*4 +: 4]  = tag;
        cdb_value[port*32 +: 32] = val;
    endtask

    task automatic cdb_clr();
        cdb_valid  = '0;
        cdb_rob_id = '0;
        cdb_value  = '0;
    endtask

    task automatic iss(input int rob, input logic ri, input logic [31:0] vi,
                       input logic rj, input logic [31:0] vj, input logic [3:0] qj);
        is_issue     = 1'b1;
        issue_rob_id = 4'(rob);
        issue_opcode = 6'(rob);
        issue_imm    = 32'h100 + 32'(rob);
        issue_pc     = 32'h1000 + 32'(rob);
        issue_Ri     = ri;
        issue_Vi     = vi;
        issue_Qi     = 4'd0;
        issue_Rj     = rj;
        issue_Vj     = vj;
        issue_Qj     = qj;
        step();
        is_issue     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0; is_issue = 1'b0; alu_ready = 1'b1;
        issue_opcode = '0; issue_rob_id = '0; issue_Qi = '0; issue_Qj = '0;
        issue_Vi = '0; issue_Vj = '0; issue_imm = '0; issue_pc = '0;
        issue_Ri = 1'b0; issue_Rj = 1'b0;
        cdb_clr();
        step(); step();
        rst = 1'b1;
        chk("rst_work_en", 32'(work_en), 0);
        chk("rst_count", 32'(rs_count), 0);
        chk("rst_full", 32'(rs_full), 0);

        // Wakeup through port 1; port 2 carries the same tag and must lose.
        iss(3, 1'b1, 32'd5, 1'b0, 32'd0, 4'd7);
        chk("wk_count_issue", 32'(rs_count), 1);
        chk("wk_not_ready", 32'(work_en), 0);
        cdb_set(1, 4'd7, 32'd9);
        cdb_set(2, 4'd7, 32'h77);
        step();
        cdb_clr();
        chk("wk_no_comb_path", 32'(work_en), 0);
        step();
        chk("wk_work_en", 32'(work_en), 1);
        chk("wk_rob", 32'(rob_id_from_rs), 3);
        chk("wk_val1", val1, 32'd5);
        chk("wk_val2_lowport", val2, 32'd9);
        chk("wk_opcode", 32'(opcode_from_rs), 3);
        chk("wk_imm", imm_from_rs, 32'h103);
        chk("wk_pc", pc_from_rs, 32'h1003);
        chk("wk_count_freed", 32'(rs_count), 0);
        step();
        chk("wk_idle", 32'(work_en), 0);

        // Oldest-first: rob1 lands in a higher slot than the later rob3.
        iss(8, 1'b1, 32'h8, 1'b0, 32'd0, 4'd9);
        iss(9, 1'b1, 32'h9, 1'b0, 32'd0, 4'd10);
        iss(1, 1'b1, 32'h101, 1'b0, 32'd0, 4'd5);
        chk("age_count3", 32'(rs_count), 3);
        cdb_set(0, 4'd9, 32'h99);
        step();
        cdb_clr();
        iss(2, 1'b1, 32'h102, 1'b0, 32'd0, 4'd5);
        chk("age_f1_rob", 32'(rob_id_from_rs), 8);
        chk("age_f1_val2", val2, 32'h99);
        chk("age_count_swap", 32'(rs_count), 3);
        iss(3, 1'b1, 32'h103, 1'b0, 32'd0, 4'd5);
        chk("age_idle", 32'(work_en), 0);
        chk("age_count4", 32'(rs_count), 4);
        cdb_set(2, 4'd5, 32'h55);
        step();
        cdb_clr();
        step();
        chk("age_first_rob", 32'(rob_id_from_rs), 1);
        chk("age_first_v1", val1, 32'h101);
        chk("age_first_v2", val2, 32'h55);
        step();
        chk("age_second_rob", 32'(rob_id_from_rs), 2);
        chk("age_second_v1", val1, 32'h102);
        step();
        chk("age_third_rob", 32'(rob_id_from_rs), 3);
        chk("age_third_en", 32'(work_en), 1);
        chk("age_count1", 32'(rs_count), 1);
        step();
        chk("age_drained", 32'(work_en), 0);

        // Backpressure with two ready entries.
        alu_ready = 1'b0;
        iss(4, 1'b1, 32'h41, 1'b1, 32'h42, 4'd0);
        iss(5, 1'b1, 32'h51, 1'b1, 32'h52, 4'd0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_work_en", 32'(work_en), 1);
            chk("bp_rob_hold", 32'(rob_id_from_rs), 4);
            chk("bp_val1_hold", val1, 32'h41);
            chk("bp_count", 32'(rs_count), 2);
            step();
        end
        alu_ready = 1'b1;
        step();
        chk("bp_rel1_rob", 32'(rob_id_from_rs), 5);
        chk("bp_rel1_val2", val2, 32'h52);
        chk("bp_rel1_en", 32'(work_en), 1);
        step();
        chk("bp_rel2_en", 32'(work_en), 0);
        chk("bp_rel2_count", 32'(rs_count), 1);

        // rdy low: issue and CDB are both ignored.
        rdy = 1'b0;
        cdb_set(0, 4'd10, 32'hAA);
        iss(7, 1'b1, 32'h71, 1'b1, 32'h72, 4'd0);
        cdb_clr();
        rdy = 1'b1;
        chk("rdy_count", 32'(rs_count), 1);
        step();
        chk("rdy_no_wake", 32'(work_en), 0);

        // Reset with entries present and a dispatch pending.
        alu_ready = 1'b0;
        iss(6, 1'b1, 32'h61, 1'b1, 32'h62, 4'd0);
        step();
        iss(7, 1'b1, 32'h71, 1'b1, 32'h72, 4'd0);
        chk("pre_rst_en", 32'(work_en), 1);
        chk("pre_rst_count", 32'(rs_count), 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst2_work_en", 32'(work_en), 0);
        chk("rst2_count", 32'(rs_count), 0);
        chk("rst2_full", 32'(rs_full), 0);
        chk("rst2_val1", val1, 32'd0);
        chk("rst2_rob", 32'(rob_id_from_rs), 0);

        // Same via clear.
        iss(6, 1'b1, 32'h61, 1'b1, 32'h62, 4'd0);
        step();
        iss(7, 1'b1, 32'h71, 1'b1, 32'h72, 4'd0);
        chk("pre_clr_en", 32'(work_en), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_work_en", 32'(work_en), 0);
        chk("clr_count", 32'(rs_count), 0);
        chk("clr_val2", val2, 32'd0);
        alu_ready = 1'b1;
        step(); step();
        chk("clr_no_stale", 32'(work_en), 0);

        // Fill to full, then drop issues (including alongside a dispatch).
        for (int i = 0; i < 16; i++) begin
            iss(i, 1'b1, 32'h200 + 32'(i), 1'b0, 32'd0, 4'd15);
            if (i == 14) chk("fill_not_full", 32'(rs_full), 0);
        end
        chk("full_count", 32'(rs_count), 16);
        chk("full_flag", 32'(rs_full), 1);
        iss(14, 1'b1, 32'hEE, 1'b1, 32'hEF, 4'd0);
        chk("full_drop_count", 32'(rs_count), 16);
        cdb_set(0, 4'd15, 32'hF0);
        step();
        cdb_clr();
        iss(14, 1'b1, 32'hEE, 1'b1, 32'hEF, 4'd0);
        chk("full_disp_rob", 32'(rob_id_from_rs), 0);
        chk("full_disp_val1", val1, 32'h200);
        chk("full_disp_val2", val2, 32'hF0);
        chk("full_drop_with_disp", 32'(rs_count), 15);
        chk("full_cleared_flag", 32'(rs_full), 0);
        step();
        chk("full_next_rob", 32'(rob_id_from_rs), 1);
        chk("full_next_count", 32'(rs_count), 14);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Issue-time bypass from a CDB port.
        cdb_set(0, 4'd4, 32'hABCD);
        iss(6, 1'b1, 32'h66, 1'b0, 32'd0, 4'd4);
        cdb_clr();
        chk("byp_count", 32'(rs_count), 1);
        chk("byp_not_yet", 32'(work_en), 0);
        step();
        chk("byp_work_en", 32'(work_en), 1);
        chk("byp_rob", 32'(rob_id_from_rs), 6);
        chk("byp_val1", val1, 32'h66);
        chk("byp_val2", val2, 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
- Parametrised reservation station. It holds issued ALU-class instructions until both operands are resolved, then dispatches them to the ALU.
- Extends the single-port station in four ways: configurable depth and tag width, N result-broadcast (CDB) ports, oldest-first selection, and a valid/ready backpressure handshake to the ALU.
- Sits between the dispatcher (issue side) and the ALU. It snoops the ALU, LSB and ROB result buses through the generic CDB ports.

Parameters:
- DEPTH, 16, number of entries (power of two, ≥2).
- ROB_W, 4, ROB tag width.
- OP_W, 6, opcode width.
- N_CDB, 3, number of result-broadcast ports.
- IDX_W, clog2(DEPTH), localparam, entry index / count width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- clear  in  1  synchronous flush (mispredict), active-high.
- is_issue  in  1  write one entry this cycle.
- issue_opcode  in  OP_W
- issue_rob_id  in  ROB_W
- issue_Vi / issue_Vj  in  32  operand values.
- issue_Qi / issue_Qj  in  ROB_W  producer tags.
- issue_Ri / issue_Rj  in  1  operand already valid.
- issue_imm / issue_pc  in  32
- rs_full  out  1  no free entry.
- rs_count  out  IDX_W+1  occupied entries.
- cdb_valid  in  N_CDB  per-port broadcast valid.
- cdb_rob_id  in  N_CDB*ROB_W  port k occupies bits [k*ROB_W +: ROB_W].
- cdb_value  in  N_CDB*32  port k occupies bits [k*32 +: 32].
- work_en  out  1  dispatch valid.
- alu_ready  in  1  ALU accepts the dispatch this cycle.
- rob_id_from_rs  out  ROB_W
- opcode_from_rs  out  OP_W
- val1 / val2  out  32
- imm_from_rs / pc_from_rs  out  32

Behaviour:
- Reset/flush: when !rst or clear at a clock edge (with rdy ignored):
  - all entries become free, age state clears;
  - work_en=0, rs_count=0, rs_full=0;
  - data outputs go to 0.
  - Reset takes precedence over clear.
- rdy=0: no state changes; inputs are ignored, including CDB.
- Occupancy:
  - rs_full = (rs_count==DEPTH), driven from registered state.
  - An issue while rs_full=1 is dropped with no effect, even if a dispatch frees an entry in the same cycle.
  - A free slot is any free entry; which one is chosen is implementation-defined.
- Issue wakeup bypass: if an issued operand has R=0 and its Q matches a valid CDB port in the same cycle, the entry is written with R=1 and V=that cdb_value.
- Wakeup:
  - For every busy entry with Ri=0 (Rj=0), a matching valid CDB port sets R=1 and V=value at the edge.
  - Multiple ports matching the same tag: the lowest port index wins.
  - Qi/Qj are don't-care once R=1.
- Ready: busy && Ri && Rj, evaluated on registered state. An entry woken or issued at edge t is dispatch-eligible from cycle t+1; there is no combinational CDB-to-dispatch path.
- Selection: among ready entries, pick the one issued earliest (strict issue order, independent of slot index). Age order must stay correct across wrap, frees and refills.
- Output register:
  - It loads when (!work_en || alu_ready) and at least one entry is ready.
  - On load: work_en=1, fields are copied from the selected entry, and that entry is freed at the same edge.
  - If the register loads nothing, work_en becomes 0 when (!work_en || alu_ready), and otherwise holds.
  - While work_en && !alu_ready, all dispatch outputs are held stable and no entry is freed.
  - Throughput: one dispatch per cycle when alu_ready stays high.
- Simultaneous events in one cycle are all legal: issue + dispatch + N_CDB wakeups. rs_count changes by +1, -1, or 0 accordingly.
- CDB tag matching uses only entries that are busy at the edge. A freed entry never captures.

Test Plan:
- Reset/flush: hold rst=0 one edge, with entries present and work_en=1 beforehand -> work_en=0, rs_count=0, rs_full=0. Repeat via clear=1 with the same result.
- Operand wakeup: issue rob 3 with Ri=1, Vi=5, Rj=0, Qj=7. Then set cdb_valid[1]=1, rob_id 7, value 9 -> next cycle work_en=1, val1=5, val2=9, rob_id_from_rs=3.
- Oldest-first: issue rob 1, 2, 3, all waiting on tag 5. Broadcast tag 5 once -> dispatches come out in order 1, 2, 3 on consecutive cycles with alu_ready=1.
- Backpressure: keep alu_ready=0 for 4 cycles with 2 ready entries -> outputs stable and rs_count unchanged (2) during the stall. After release, 2 dispatches occur in the next 2 cycles.
- Full/bypass:
  - Fill DEPTH=16 entries -> rs_full=1. Issue again -> dropped, and rs_count stays 16.
  - Issue with Qj=4 while cdb tag 4, value 0xABCD is valid that cycle -> the entry dispatches later with val2=0xABCD.
